// File: rtl/user_ip_gpio_seq_pkg.sv
// Shared types, register map and field widths for the GPIO pattern sequencer.
package user_ip_gpio_seq_pkg;

    localparam int USER_GPIO_NUM = 16;
    localparam int NUM_STEPS     = 8;
    localparam int STEP_IDX_W    = 3;
    localparam int DIV_W         = 8;
    localparam int DUR_W         = 16;
    localparam int PAT_W         = 16;
    localparam int PAT_LSB       = 16;

    localparam logic [7:0] OFF_ID    = 8'h00;
    localparam logic [7:0] OFF_CTRL  = 8'h04;
    localparam logic [7:0] OFF_DIV   = 8'h08;
    localparam logic [7:0] OFF_NSTEP = 8'h0C;
    localparam logic [7:0] OFF_IDLE  = 8'h10;
    localparam logic [7:0] OFF_STAT  = 8'h14;
    localparam logic [7:0] OFF_STEP0 = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } gpio_seq_state_e;

    // A programmed duration of 0 behaves like 1 tick.
    function automatic logic [DUR_W:0] dur_eff(input logic [DUR_W-1:0] dur);
        return (dur == '0) ? {{DUR_W{1'b0}}, 1'b1} : {1'b0, dur};
    endfunction

endpackage

// File: rtl/apb4_if.sv
// APB4 bus bundle, 32-bit address and data.
interface apb4_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/user_gpio_if.sv
// User GPIO pad-control bundle for one user IP slot.
interface user_gpio_if;
    import user_ip_gpio_seq_pkg::*;

    logic [USER_GPIO_NUM-1:0] gpio_in;
    logic [USER_GPIO_NUM-1:0] gpio_out;
    logic [USER_GPIO_NUM-1:0] gpio_oe;
    logic [USER_GPIO_NUM-1:0] gpio_cs;
    logic [USER_GPIO_NUM-1:0] gpio_pu;
    logic [USER_GPIO_NUM-1:0] gpio_pd;

    modport dut (
        input  gpio_in,
        output gpio_out, gpio_oe, gpio_cs, gpio_pu, gpio_pd
    );
endinterface

// File: rtl/user_ip_gpio_seq_presc.sv
// Tick prescaler: one tick every div+1 enabled cycles; the >= compare makes a
// lowered div take effect on the very next cycle.
module user_ip_gpio_seq_presc
    import user_ip_gpio_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] presc_reg;

    assign tick = enable && (presc_reg >= div);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            presc_reg <= '0;
        end else if (enable) begin
            presc_reg <= tick ? '0 : presc_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/user_ip_gpio_seq.sv
// APB-programmed GPIO pattern sequencer: steps through up to 8 (pattern,
// duration) entries in one-shot or loop mode and drives them onto user GPIO.
module user_ip_gpio_seq
    import user_ip_gpio_seq_pkg::*;
#(
    parameter logic [7:0] ID = 8'd255
) (
    input logic      clk_i,
    input logic      rst_i,
    user_gpio_if.dut gpio,
    apb4_if.slave    apb
);

    logic [7:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic        ctrl_wr;
    logic        step_wr;
    logic        en_eff;
    logic        start_req;
    logic        stop_req;
    logic [31:0] rdata;

    logic                  en_reg;
    logic                  loop_reg;
    logic [DIV_W-1:0]      div_reg;
    logic [STEP_IDX_W-1:0] nstep_reg;
    logic [PAT_W-1:0]      idle_reg;
    logic [31:0]           step_tab [NUM_STEPS];
    logic [NUM_STEPS-1:0]  step_hit;

    gpio_seq_state_e          st_reg, st_next;
    logic [STEP_IDX_W-1:0]    step_reg, step_next;
    logic [DUR_W-1:0]         dur_cnt_reg, dur_cnt_next;
    logic                     done_flag_reg, done_flag_next;
    logic                     presc_clear;
    logic                     tick;
    logic [DUR_W-1:0]         cur_dur;
    logic [DUR_W:0]           dur_cnt_inc;
    logic [USER_GPIO_NUM-1:0] gpio_out_reg;

    assign addr      = apb.paddr[7:0];
    assign wr_en     = apb.psel & apb.penable & apb.pwrite;
    assign rd_en     = apb.psel & apb.penable & ~apb.pwrite;
    assign ctrl_wr   = wr_en && (addr == OFF_CTRL);
    assign step_wr   = wr_en && (addr[7:5] == OFF_STEP0[7:5]) && (addr[1:0] == 2'b00);
    // EN written in the same access already governs the transition.
    assign en_eff    = ctrl_wr ? apb.pwdata[0] : en_reg;
    assign start_req = ctrl_wr & apb.pwdata[2];
    assign stop_req  = ctrl_wr & apb.pwdata[3];

    for (genvar gi = 0; gi < NUM_STEPS; gi++) begin : g_step_hit
        assign step_hit[gi] = step_wr && (addr[4:2] == STEP_IDX_W'(gi));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_reg    <= 1'b0;
            loop_reg  <= 1'b0;
            div_reg   <= '0;
            nstep_reg <= '0;
            idle_reg  <= '0;
            for (int i = 0; i < NUM_STEPS; i++) begin
                step_tab[i] <= '0;
            end
        end else begin
            if (ctrl_wr) begin
                en_reg   <= apb.pwdata[0];
                loop_reg <= apb.pwdata[1];
            end
            if (wr_en && (addr == OFF_DIV))   div_reg   <= apb.pwdata[DIV_W-1:0];
            if (wr_en && (addr == OFF_NSTEP)) nstep_reg <= apb.pwdata[STEP_IDX_W-1:0];
            if (wr_en && (addr == OFF_IDLE))  idle_reg  <= apb.pwdata[PAT_W-1:0];
            for (int i = 0; i < NUM_STEPS; i++) begin
                if (step_hit[i]) step_tab[i] <= apb.pwdata;
            end
        end
    end

    user_ip_gpio_seq_presc u_presc (
        .clk    (clk_i),
        .rst    (rst_i),
        .clear  (presc_clear),
        .enable (st_reg == ST_RUN),
        .div    (div_reg),
        .tick   (tick)
    );

    assign cur_dur     = step_tab[step_reg][DUR_W-1:0];
    assign dur_cnt_inc = {1'b0, dur_cnt_reg} + {{DUR_W{1'b0}}, 1'b1};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_reg        <= ST_IDLE;
            step_reg      <= '0;
            dur_cnt_reg   <= '0;
            done_flag_reg <= 1'b0;
        end else begin
            st_reg        <= st_next;
            step_reg      <= step_next;
            dur_cnt_reg   <= dur_cnt_next;
            done_flag_reg <= done_flag_next;
        end
    end

    always_comb begin
        st_next        = st_reg;
        step_next      = step_reg;
        dur_cnt_next   = dur_cnt_reg;
        done_flag_next = done_flag_reg;
        presc_clear    = 1'b0;
        case (st_reg)
            ST_IDLE: begin
                if (start_req && !stop_req && en_eff) begin
                    st_next        = ST_RUN;
                    step_next      = '0;
                    dur_cnt_next   = '0;
                    done_flag_next = 1'b0;
                    presc_clear    = 1'b1;
                end
            end
            ST_RUN, ST_DONE: begin
                if (stop_req || !en_eff) begin
                    st_next      = ST_IDLE;
                    step_next    = '0;
                    dur_cnt_next = '0;
                end else if (start_req) begin
                    st_next        = ST_RUN;
                    step_next      = '0;
                    dur_cnt_next   = '0;
                    done_flag_next = 1'b0;
                    presc_clear    = 1'b1;
                end else if ((st_reg == ST_RUN) && tick) begin
                    if (dur_cnt_inc >= dur_eff(cur_dur)) begin
                        dur_cnt_next = '0;
                        // >= so a NSTEP lowered below the current step still ends the pass.
                        if (step_reg >= nstep_reg) begin
                            step_next = '0;
                            if (!loop_reg) begin
                                st_next        = ST_DONE;
                                done_flag_next = 1'b1;
                            end
                        end else begin
                            step_next = step_reg + STEP_IDX_W'(1);
                        end
                    end else begin
                        dur_cnt_next = dur_cnt_inc[DUR_W-1:0];
                    end
                end
            end
            default: st_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gpio_out_reg <= '0;
        end else begin
            case (st_reg)
                ST_RUN:  gpio_out_reg <= step_tab[step_reg][PAT_LSB +: USER_GPIO_NUM];
                ST_DONE: gpio_out_reg <= step_tab[nstep_reg][PAT_LSB +: USER_GPIO_NUM];
                default: gpio_out_reg <= idle_reg[USER_GPIO_NUM-1:0];
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (addr)
                OFF_ID:    rdata = {24'd0, ID};
                OFF_CTRL:  rdata = {30'd0, loop_reg, en_reg};
                OFF_DIV:   rdata = {24'd0, div_reg};
                OFF_NSTEP: rdata = {29'd0, nstep_reg};
                OFF_IDLE:  rdata = {16'd0, idle_reg};
                OFF_STAT:  rdata = {26'd0, done_flag_reg, step_reg, st_reg};
                default: begin
                    if ((addr[7:5] == OFF_STEP0[7:5]) && (addr[1:0] == 2'b00)) begin
                        rdata = step_tab[addr[4:2]];
                    end
                end
            endcase
        end
    end

    assign apb.prdata  = rdata;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = 1'b0;

    assign gpio.gpio_out = gpio_out_reg;
    assign gpio.gpio_oe  = '1;
    assign gpio.gpio_cs  = '1;
    assign gpio.gpio_pu  = '0;
    assign gpio.gpio_pd  = '0;

    logic unused_ok;
    assign unused_ok = ^{apb.paddr[31:8], apb.pstrb, apb.pprot, gpio.gpio_in};

endmodule

// File: tb/tb_user_ip_gpio_seq.sv
// Bench for the GPIO pattern sequencer: cycle-count model of the schedule plus
// directed literal checks and randomized programs.
module tb_user_ip_gpio_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   check_en = 1'b0;

    always #5 clk = ~clk;

    apb4_if      apb();
    user_gpio_if gpio();

    user_ip_gpio_seq #(.ID(8'd255)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .gpio  (gpio),
        .apb   (apb)
    );

    // Model state: mode 0=IDLE 1=RUN 2=DONE, elapsed = cycles spent in current step.
    logic        m_en, m_loop, m_flag;
    logic [7:0]  m_div;
    logic [2:0]  m_nstep, m_step;
    logic [15:0] m_idle, m_out;
    logic [31:0] m_tab [8];
    logic [1:0]  m_mode;
    int          m_elapsed;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_en = 0; m_loop = 0; m_flag = 0; m_div = 0; m_nstep = 0; m_step = 0;
        m_idle = 0; m_out = 0; m_mode = 0; m_elapsed = 0;
        for (int i = 0; i < 8; i++) m_tab[i] = 0;
    endfunction

    function automatic void enter_run();
        m_mode = 2'd1; m_step = 0; m_elapsed = 0; m_flag = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        if (a == 8'h00) return 32'h0000_00FF;
        if (a == 8'h04) return {30'd0, m_loop, m_en};
        if (a == 8'h08) return {24'd0, m_div};
        if (a == 8'h0C) return {29'd0, m_nstep};
        if (a == 8'h10) return {16'd0, m_idle};
        if (a == 8'h14) return {26'd0, m_flag, m_step, m_mode};
        if (a >= 8'h20 && a < 8'h40 && a[1:0] == 2'b00) return m_tab[a[4:2]];
        return 32'h0;
    endfunction

    function automatic void model_step();
        logic [15:0] nxt;
        logic        wr, cw, en_new, st, sp;
        logic [7:0]  a;
        logic [31:0] d;
        int          len, dur;
        case (m_mode)
            2'd1:    nxt = m_tab[m_step][31:16];
            2'd2:    nxt = m_tab[m_nstep][31:16];
            default: nxt = m_idle;
        endcase
        if (rst) begin
            model_reset();
            return;
        end
        wr = apb.psel && apb.penable && apb.pwrite;
        a  = apb.paddr[7:0];
        d  = apb.pwdata;
        cw = wr && (a == 8'h04);
        en_new = cw ? d[0] : m_en;
        st = cw && d[2];
        sp = cw && d[3];
        if (m_mode == 2'd0) begin
            if (st && !sp && en_new) enter_run();
        end else if (sp || !en_new) begin
            m_mode = 2'd0; m_step = 0; m_elapsed = 0;
        end else if (st) begin
            enter_run();
        end else if (m_mode == 2'd1) begin
            dur = int'(m_tab[m_step][15:0]);
            if (dur == 0) dur = 1;
            len = (int'(m_div) + 1) * dur;
            if (m_elapsed + 1 >= len) begin
                m_elapsed = 0;
                if (m_step >= m_nstep) begin
                    m_step = 0;
                    if (!m_loop) begin
                        m_mode = 2'd2;
                        m_flag = 1;
                    end
                end else begin
                    m_step = m_step + 3'd1;
                end
            end else begin
                m_elapsed++;
            end
        end
        if (wr) begin
            if (a == 8'h04) begin m_en = d[0]; m_loop = d[1]; end
            if (a == 8'h08) m_div = d[7:0];
            if (a == 8'h0C) m_nstep = d[2:0];
            if (a == 8'h10) m_idle = d[15:0];
            if (a >= 8'h20 && a < 8'h40 && a[1:0] == 2'b00) m_tab[a[4:2]] = d;
        end
        m_out = nxt;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (check_en) begin
                chk("gpio_out", {16'd0, gpio.gpio_out}, {16'd0, m_out});
                chk("gpio_oe_cs", {gpio.gpio_oe, gpio.gpio_cs}, 32'hFFFF_FFFF);
                chk("gpio_pu_pd", {gpio.gpio_pu, gpio.gpio_pd}, 32'h0);
                chk("apb_resp", {30'd0, apb.pready, apb.pslverr}, 32'h2);
                if (!apb.psel) chk("prdata_idle", apb.prdata, 32'h0);
            end
        end
    end

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        apb.paddr = {24'd0, a}; apb.pwdata = d; apb.pwrite = 1'b1;
        apb.psel = 1'b1; apb.penable = 1'b0;
        @(negedge clk);
        apb.penable = 1'b1;
        @(negedge clk);
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        $display("[TB] write 0x%02h <= 0x%08h", a, d);
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic [31:0] e);
        apb.paddr = {24'd0, a}; apb.pwrite = 1'b0;
        apb.psel = 1'b1; apb.penable = 1'b0;
        #1 chk("prdata_setup", apb.prdata, 32'h0);
        @(negedge clk);
        apb.penable = 1'b1;
        #1;
        d = apb.prdata;
        e = model_read(a);
        @(negedge clk);
        apb.psel = 1'b0; apb.penable = 1'b0;
        $display("[TB] read  0x%02h => 0x%08h", a, d);
    endtask

    task automatic read_check(input logic [7:0] a);
        logic [31:0] d, e;
        apb_read(a, d, e);
        chk($sformatf("read_%02h", a), d, e);
    endtask

    task automatic read_lit(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d, e;
        apb_read(a, d, e);
        chk(name, d, exp);
    endtask

    task automatic expect_out(input string name, input logic [15:0] exp);
        #1 chk(name, {16'd0, gpio.gpio_out}, {16'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        fails++;
        $display("FAIL watchdog: got timeout, expected $finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [31:0] d, e;
        logic        lp;
        int          r;
        apb.paddr = 0; apb.pwdata = 0; apb.pwrite = 0; apb.psel = 0; apb.penable = 0;
        apb.pstrb = 4'hF; apb.pprot = 3'd0;
        gpio.gpio_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;

        // Reset state
        expect_out("reset_out", 16'h0);
        read_lit("reset_id", 8'h00, 32'h0000_00FF);
        read_lit("reset_stat", 8'h14, 32'h0);
        read_lit("reset_idle", 8'h10, 32'h0);

        // One-shot: 0x5 for 6 cycles, 0xA for 4, then DONE holding 0xA
        apb_write(8'h08, 32'd1);
        apb_write(8'h0C, 32'd1);
        apb_write(8'h20, 32'h0005_0003);
        apb_write(8'h24, 32'h000A_0002);
        apb_write(8'h04, 32'h5);
        expect_out("oneshot_s0", 16'h0);
        for (int i = 1; i <= 12; i++) expect_out($sformatf("oneshot_s%0d", i), (i <= 6) ? 16'h5 : 16'hA);
        read_lit("oneshot_stat_done", 8'h14, 32'h22);

        // Loop: period 10 cycles
        apb_write(8'h04, 32'h9);
        apb_write(8'h04, 32'h7);
        expect_out("loop_s0", 16'h0);
        for (int i = 1; i <= 20; i++) expect_out($sformatf("loop_s%0d", i), (((i - 1) % 10) < 6) ? 16'h5 : 16'hA);
        apb_read(8'h14, d, e);
        chk("loop_stat_run", d & 32'h3, 32'h1);
        for (int i = 0; i < 4; i++) read_check(8'h14);

        // DUR=0 with DIV=0: one cycle per step
        apb_write(8'h04, 32'h9);
        apb_write(8'h08, 32'd0);
        apb_write(8'h20, 32'h0003_0000);
        apb_write(8'h24, 32'h000C_0000);
        apb_write(8'h04, 32'h5);
        expect_out("dur0_s0", 16'h0);
        expect_out("dur0_s1", 16'h3);
        expect_out("dur0_s2", 16'hC);
        expect_out("dur0_s3", 16'hC);
        read_lit("dur0_stat_done", 8'h14, 32'h22);

        // Lowering DIV mid-count forces a tick on the next cycle
        apb_write(8'h04, 32'h9);
        apb_write(8'h08, 32'd255);
        apb_write(8'h20, 32'h0011_0001);
        apb_write(8'h24, 32'h0022_0001);
        apb_write(8'h04, 32'h5);
        repeat (20) @(negedge clk);
        expect_out("slowdiv_hold", 16'h11);
        apb_write(8'h08, 32'd0);
        expect_out("livediv_s0", 16'h11);
        expect_out("livediv_s1", 16'h11);
        expect_out("livediv_s2", 16'h22);

        // START|STOP together: STOP wins
        apb_write(8'h10, 32'h0000_BEEF);
        apb_write(8'h04, 32'h7);
        repeat (5) @(negedge clk);
        apb_write(8'h04, 32'hD);
        @(negedge clk);
        expect_out("startstop_idle", 16'hBEEF);
        read_lit("startstop_stat", 8'h14, 32'h0);

        // Clearing EN while running
        apb_write(8'h04, 32'h7);
        repeat (5) @(negedge clk);
        apb_write(8'h04, 32'h0);
        @(negedge clk);
        expect_out("enclr_idle", 16'hBEEF);
        read_lit("enclr_ctrl", 8'h04, 32'h0);
        read_lit("enclr_stat", 8'h14, 32'h0);

        // Reset during RUN coincident with a START write
        apb_write(8'h04, 32'h7);
        repeat (5) @(negedge clk);
        apb.paddr = 32'h04; apb.pwdata = 32'h5; apb.pwrite = 1'b1; apb.psel = 1'b1; apb.penable = 1'b0;
        @(negedge clk);
        apb.penable = 1'b1; rst = 1'b1;
        @(negedge clk);
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; rst = 1'b0;
        $display("[TB] reset pulse with START write");
        expect_out("rst_out", 16'h0);
        read_lit("rst_ctrl", 8'h04, 32'h0);
        read_lit("rst_div", 8'h08, 32'h0);
        read_lit("rst_nstep", 8'h0C, 32'h0);
        read_lit("rst_idle", 8'h10, 32'h0);
        read_lit("rst_stat", 8'h14, 32'h0);
        read_lit("rst_step0", 8'h20, 32'h0);
        read_lit("rst_step1", 8'h24, 32'h0);
        read_lit("rst_id", 8'h00, 32'h0000_00FF);

        // Randomized programs checked against the model
        for (int it = 0; it < 8; it++) begin
            apb_write(8'h08, 32'($urandom_range(0, 3)));
            apb_write(8'h0C, 32'($urandom_range(0, 7)));
            for (int k = 0; k < 8; k++) apb_write(8'(8'h20 + k * 4), {16'($urandom), 16'($urandom_range(0, 4))});
            apb_write(8'h10, $urandom);
            apb_write(8'h14, $urandom);
            apb_write(8'h00, $urandom);
            apb_write(8'h18, $urandom);
            lp = 1'($urandom_range(0, 1));
            apb_write(8'h04, {29'd0, 1'b1, lp, 1'b1});
            for (int op = 0; op < 40; op++) begin
                r = $urandom_range(0, 19);
                if (r < 8) read_check(8'h14);
                else if (r < 11) read_check(8'($urandom_range(0, 255)));
                else if (r == 11) apb_write(8'h04, 32'($urandom_range(0, 15)));
                else repeat ($urandom_range(1, 6)) @(negedge clk);
            end
            apb_write(8'h04, 32'h9);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/user_ip_gpio_seq.md
# user_ip_gpio_seq

APB-programmed GPIO pattern sequencer occupying one user IP slot. It steps through a table of up to 8 (pattern, duration) entries and drives each pattern onto the user GPIO pins for a programmable number of prescaled ticks. It supports one-shot and loop modes. It is the controller that schedules the user GPIO output resource in time; software only configures it and starts it.

## Interface
Parameters:
- `ID`, 8'd255: slot identifier, returned at offset 0x00.

Ports:
- `clk_i`, input, 1: single clock domain.
- `rst_i`, input, 1: synchronous, active-high reset.
- `gpio`, `user_gpio_if.dut`, `USER_GPIO_NUM` wide (≤16): user pad control.
- `apb`, `apb4_if.slave`, 32-bit: register access. `pready`=1 and `pslverr`=0 always.

## Operation
Registers (byte offset on `paddr[7:0]`; all read 0 unless noted):
- 0x00 ID (ro): {24'd0, ID}.
- 0x04 CTRL (rw):
  - [0] EN.
  - [1] LOOP.
  - [2] START: write-1 pulse, reads 0.
  - [3] STOP: write-1 pulse, reads 0.
- 0x08 DIV (rw) [7:0]: one tick every DIV+1 clocks.
- 0x0C NSTEP (rw) [2:0]: index of the last step; the sequence runs steps 0..NSTEP.
- 0x10 IDLE (rw) [15:0]: pattern driven in IDLE.
- 0x14 STAT (ro):
  - [1:0] state: IDLE=0, RUN=1, DONE=2.
  - [4:2] current step.
  - [5] DONE_FLAG: set on entry to DONE, cleared on START.
- 0x20+4k, k=0..7, STEP[k] (rw):
  - [15:0] DUR, in ticks; 0 is treated as 1.
  - [31:16] PAT, only the low `USER_GPIO_NUM` bits are used.
- Unmapped reads return 0. Writes to unmapped or read-only offsets are ignored.

State machine, state register `st`:
- IDLE → RUN: START=1, STOP=0, EN=1 (new EN value in the same write also counts). On entry: step=0, prescaler=0, dur_cnt=0, DONE_FLAG=0.
- RUN:
  - Prescaler tick when presc ≥ DIV; presc then returns to 0, otherwise it increments.
  - On a tick, if dur_cnt+1 ≥ max(DUR[step],1): advance, dur_cnt=0. Otherwise dur_cnt increments.
  - Advance at step==NSTEP with LOOP=1: step=0. With LOOP=0: go to DONE. Otherwise step+1.
- RUN → IDLE: STOP write, or EN cleared.
- RUN, START alone: restart at step 0 with the entry actions.
- DONE → RUN: START (entry actions).
- DONE → IDLE: STOP, or EN cleared.
- START and STOP in the same write: STOP wins.

GPIO output:
- `gpio_out`:
  - IDLE: IDLE pattern.
  - RUN: STEP[step].PAT.
  - DONE: STEP[NSTEP].PAT.
- `gpio_oe`='1, `gpio_cs`='1, `gpio_pu`='0, `gpio_pd`='0.
- `gpio_out` is registered: it reflects `st` and `step` one cycle after they change.

Live programming:
- Table, DIV and NSTEP are sampled live each cycle.
- Lowering DIV below the current presc causes a tick on the next cycle, because the compare is ≥.
- Lowering NSTEP below step: the advance from step wraps or finishes per LOOP, because the compare is ≥ NSTEP.

## Timing
- Reset values:
  - All registers 0, `st`=IDLE, step=0, presc=0, dur_cnt=0.
  - `gpio_out`=0 the cycle after reset is released, since IDLE reg=0.
  - `prdata`=0.
- APB: zero wait state. A write takes effect on the clock edge that ends the access phase.
- Read data is combinational and is driven only during `psel & penable & ~pwrite`, else 0.
- START written at access edge T:
  - `st`=RUN from T+1.
  - `gpio_out`=PAT[0] from T+2.
- Step k lasts exactly (DIV+1)·max(DUR[k],1) cycles when registers are static.
- One-shot of S=NSTEP+1 steps:
  - DONE is reached Σ over steps after T+1.
  - DONE_FLAG is visible in STAT at that same cycle.
- STOP at edge T: `st`=IDLE at T+1, `gpio_out`=IDLE at T+2.
- `rst_i` mid-run: the next cycle is in reset state regardless of any APB write in that cycle.

## Structure
- Package `user_ip_gpio_seq_pkg`:
  - State enum `gpio_seq_state_e`.
  - Register offset localparams.
  - Step-count constant, 8.
  - Field width constants.
- Sub-module `user_ip_gpio_seq_presc`:
  - Inputs: clk, rst, clear, enable, div[7:0].
  - Output: tick pulse.
  - Holds presc with the ≥ compare.
- Top holds the APB decode, register file (8×32 table plus control regs), FSM, step and duration counters, and the output register.

## Test plan
- Reset, then read 0x00/0x14/0x10 → ID, 0, 0; `gpio_out`=0; `gpio_oe` all ones.
- DIV=1, NSTEP=1, STEP0={DUR 3, PAT 0x5}, STEP1={DUR 2, PAT 0xA}, CTRL=EN|START:
  - PAT 0x5 is held 6 cycles, then 0xA for 4 cycles.
  - Then DONE: STAT=0x22 (DONE_FLAG=1, st=2), pattern 0xA held.
- Same program with LOOP=1 → the pattern alternates 0x5/0xA indefinitely with period 10 cycles; STAT step cycles 0,1.
- DUR=0, DIV=0 on a single step → that step lasts 1 cycle. Write DIV=255 then DIV=0 mid-count → tick on the next cycle.
- Write START|STOP while in RUN → IDLE next cycle, `gpio_out`=IDLE pattern. Clear EN during RUN → IDLE.
- Assert `rst_i` for 1 cycle during RUN, coincident with a START write → IDLE, all regs 0, START ignored.
